// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } fetch_state_t;

  localparam logic [31:0] INST_NOP = 32'h00000013;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/inst_fetch_unit.sv
// PC and fetch stage: issues word addresses to a synchronous instruction RAM, tags the
// returning word with its PC, and presents {pc, inst, valid} to IF/ID. Stalls are absorbed
// by a one-word hold register because the RAM re-reads the next address while stalled.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       if_pc_o,
  output logic [31:0]       if_inst_o,
  output logic              if_valid_o,
  output logic              misalign_o
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;         // address being presented to the RAM this cycle
  logic [31:0]  r_rsp_pc;     // PC of the word currently on imem_rdata_i (or held)
  logic         r_rsp_valid;
  logic [31:0]  r_hold_inst;  // word captured when a stall starts
  logic         r_misalign;

  logic [31:0]  w_pc_next;
  logic [31:0]  w_target;

  assign w_pc_next = r_pc + PC_STEP;
  assign w_target  = {redirect_pc_i[31:2], 2'b00};

  // State update: redirect beats stall, stall beats advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= BOOT;
      r_pc        <= RESET_PC;
      r_rsp_pc    <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_hold_inst <= 32'h0;
      r_misalign  <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if (redirect_i) begin
        // In-flight RAM word belongs to the old path; drop it and take one bubble.
        r_pc        <= w_target;
        r_rsp_valid <= 1'b0;
        r_state     <= RUN;
        r_misalign  <= |redirect_pc_i[1:0];
      end else begin
        case (r_state)
          BOOT: begin
            if (!stall_i) begin
              r_rsp_pc    <= r_pc;
              r_rsp_valid <= 1'b1;
              r_pc        <= w_pc_next;
              r_state     <= RUN;
            end
          end
          RUN: begin
            if (!stall_i) begin
              r_rsp_pc    <= r_pc;
              r_rsp_valid <= 1'b1;
              r_pc        <= w_pc_next;
            end else begin
              // RAM output will change to mem[r_pc] next cycle, so keep the shown word.
              r_hold_inst <= imem_rdata_i;
              r_state     <= HOLD;
            end
          end
          HOLD: begin
            if (!stall_i) begin
              // RAM has been re-reading r_pc; issuing it again keeps the stream gapless.
              r_rsp_pc    <= r_pc;
              r_rsp_valid <= 1'b1;
              r_pc        <= w_pc_next;
              r_state     <= RUN;
            end
          end
          default: begin
            r_state <= BOOT;
          end
        endcase
      end
    end
  end

  // Output mux: hold register while stalled, live RAM data otherwise, NOP when empty.
  always_comb begin
    if_inst_o = INST_NOP;
    if (r_rsp_valid) begin
      if_inst_o = (r_state == HOLD) ? r_hold_inst : imem_rdata_i;
    end
  end

  assign imem_addr_o = r_pc[ADDR_W+1:2];
  assign if_pc_o     = r_rsp_pc;
  assign if_valid_o  = r_rsp_valid;
  assign misalign_o  = r_misalign;

endmodule
